// File: rtl/posit_mult_pipe_if.sv
// Operand/result stream bundle for posit_mult_pipe: valid/ready on both sides plus a sideband tag.
interface posit_mult_pipe_if #(
    parameter int N     = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_p;
    logic [TAG_W-1:0] out_tag;
    logic             out_nar;
    logic             out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, out_nar, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, out_nar, out_zero
    );
endinterface

// File: rtl/posit_mult_pipe.sv
// Three-stage posit multiplier (decode / multiply / encode+RNE) with valid/ready flow control,
// saturating at maxpos/minpos and carrying a user tag per operation.
module posit_mult_pipe #(
    parameter int N     = 16,
    parameter int ES    = 3,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic rst_n,
    posit_mult_pipe_if.slave io
);
    localparam int W    = N - 1;
    localparam int MW   = N - ES;
    localparam int FW   = 2 * MW - 1;
    localparam int SW   = $clog2(N) + ES + 3;
    localparam int EW   = (ES > 0) ? ES : 1;
    localparam int BW   = ES + FW;
    localparam int TF   = 1 + BW + N;
    localparam int MAXS = (N - 2) << ES;
    localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINP = {{(N-1){1'b0}}, 1'b1};

    function automatic void decode(input  logic [N-1:0]         x,
                                   output logic                 sgn,
                                   output logic signed [SW-1:0] scale,
                                   output logic [MW-1:0]        mant);
        logic [W-1:0] rem;
        logic [W-1:0] sh;
        int unsigned  run;
        logic         done;
        int           k;
        sgn  = x[N-1];
        rem  = W'(sgn ? -x : x);
        run  = 0;
        done = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!done && rem[W-1-i] == rem[W-1]) run++;
            else done = 1'b1;
        end
        k     = rem[W-1] ? int'(run) - 1 : -int'(run);
        // Drop regime run and terminator; exponent then fraction sit left-aligned, missing bits are zero.
        sh    = rem << (run + 1);
        scale = SW'(k * (1 << ES) + int'(sh >> (W - ES)));
        mant  = {1'b1, sh[W-1-ES:0]};
    endfunction

    logic ld1, ld2, ld3;

    logic                 s1_valid, s1_sign, s1_nar, s1_zero;
    logic signed [SW-1:0] s1_sa, s1_sb;
    logic [MW-1:0]        s1_ma, s1_mb;
    logic [TAG_W-1:0]     s1_tag;

    logic                 s2_valid, s2_sign, s2_nar, s2_zero;
    logic signed [SW-1:0] s2_scale;
    logic [FW-1:0]        s2_frac;
    logic [TAG_W-1:0]     s2_tag;

    logic                 o_valid, o_nar, o_zero;
    logic [N-1:0]         o_p;
    logic [TAG_W-1:0]     o_tag;

    assign ld3         = ~o_valid | io.out_ready;
    assign ld2         = ~s2_valid | ld3;
    assign ld1         = ~s1_valid | ld2;
    assign io.in_ready = ld1;
    assign io.out_valid = o_valid;
    assign io.out_p     = o_p;
    assign io.out_tag   = o_tag;
    assign io.out_nar   = o_nar;
    assign io.out_zero  = o_zero;

    logic                 da_s, db_s;
    logic signed [SW-1:0] da_sc, db_sc;
    logic [MW-1:0]        da_m, db_m;

    always_comb begin
        decode(io.in_a, da_s, da_sc, da_m);
        decode(io.in_b, db_s, db_sc, db_m);
    end

    logic [2*MW-1:0]      prod;
    logic [FW-1:0]        frac2;
    logic signed [SW-1:0] scale2;

    always_comb begin
        prod   = s1_ma * s1_mb;
        frac2  = prod[2*MW-1] ? prod[2*MW-2:0] : {prod[2*MW-3:0], 1'b0};
        scale2 = SW'(int'(s1_sa) + int'(s1_sb) + int'(prod[2*MW-1]));
    end

    int            k3;
    int            r3;
    logic [EW-1:0] e3;
    logic [BW-1:0] body;
    logic [TF-1:0] t3;
    logic [2*N-1:0] pack;
    logic [W-1:0]  mag;
    logic          guard, sticky;
    logic [N-1:0]  rnd, enc;

    always_comb begin
        k3     = int'(s2_scale) >>> ES;
        e3     = EW'(int'(s2_scale) - (k3 << ES));
        r3     = (k3 >= 0) ? k3 + 1 : -k3;
        body   = (BW'(e3) << FW) | BW'(s2_frac);
        t3     = {(k3 < 0), body, {N{1'b0}}} >> r3;
        if (k3 >= 0) t3 = t3 | ~({TF{1'b1}} >> r3);
        pack   = {t3[TF-1 -: 2*N-1], |t3[TF-2*N:0]};
        mag    = pack[2*N-1 -: W];
        guard  = pack[N];
        sticky = |pack[N-1:0];
        // Round-up carry ripples through exponent/regime naturally as an integer increment.
        rnd    = {1'b0, mag} + N'(guard & (sticky | mag[0]));
        if (int'(s2_scale) > MAXS || rnd[N-1]) enc = MAXP;
        else if (int'(s2_scale) < -MAXS || rnd == '0) enc = MINP;
        else enc = rnd;
        if (s2_sign) enc = -enc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_sa    <= '0;
            s1_sb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_nar   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_scale <= '0;
            s2_frac  <= '0;
            s2_tag   <= '0;
            o_valid  <= 1'b0;
            o_nar    <= 1'b0;
            o_zero   <= 1'b0;
            o_p      <= '0;
            o_tag    <= '0;
        end else begin
            if (ld1) begin
                s1_valid <= io.in_valid;
                if (io.in_valid) begin
                    s1_sign <= da_s ^ db_s;
                    s1_nar  <= (io.in_a == NAR) || (io.in_b == NAR);
                    s1_zero <= (io.in_a == '0) || (io.in_b == '0);
                    s1_sa   <= da_sc;
                    s1_sb   <= db_sc;
                    s1_ma   <= da_m;
                    s1_mb   <= db_m;
                    s1_tag  <= io.in_tag;
                end
            end
            if (ld2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sign  <= s1_sign;
                    s2_nar   <= s1_nar;
                    s2_zero  <= s1_zero;
                    s2_scale <= scale2;
                    s2_frac  <= frac2;
                    s2_tag   <= s1_tag;
                end
            end
            if (ld3) begin
                o_valid <= s2_valid;
                if (s2_valid) begin
                    o_tag  <= s2_tag;
                    o_nar  <= s2_nar;
                    o_zero <= ~s2_nar & s2_zero;
                    if (s2_nar)       o_p <= NAR;
                    else if (s2_zero) o_p <= '0;
                    else              o_p <= enc;
                end
            end
        end
    end
endmodule

// File: tb/tb_posit_mult_pipe.sv
// Self-checking bench for posit_mult_pipe: directed products, specials, saturation,
// backpressure and mid-stream reset, all checked against a bit-string posit reference model.
module tb_posit_mult_pipe;
    localparam int N     = 16;
    localparam int ES    = 3;
    localparam int TAG_W = 4;
    localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINP = {{(N-1){1'b0}}, 1'b1};
    localparam bit RDY_PAT [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    posit_mult_pipe_if #(.N(N), .TAG_W(TAG_W)) io ();

    posit_mult_pipe #(.N(N), .ES(ES), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]     p;
        logic             nar;
        logic             zero;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0, cyc = 0, delivered = 0;
    bit   lat_chk = 1'b0, hold_pend = 1'b0, accepted = 1'b0;
    logic [N-1:0]     held_p, last_p;
    logic [TAG_W-1:0] held_tag, last_tag;
    logic             held_nar, held_zero, last_nar, last_zero;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: read the posit as a bit stream (regime run, exponent, fraction).
    function automatic void pdecode(input logic [N-1:0] p, output bit s, output int scale,
                                    output longint mant, output int fl);
        bit q[$];
        logic [N-1:0] m;
        int run, k, e;
        s = p[N-1];
        m = s ? -p : p;
        for (int i = N - 2; i >= 0; i--) q.push_back(m[i]);
        run = 1;
        while (run < q.size() && q[run] == q[0]) run++;
        k = q[0] ? run - 1 : -run;
        for (int i = 0; i < run + 1; i++) if (q.size() > 0) void'(q.pop_front());
        e = 0;
        for (int i = 0; i < ES; i++) e = e * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
        mant = 1;
        fl   = 0;
        while (q.size() > 0) begin
            mant = mant * 2 + longint'(q.pop_front());
            fl++;
        end
        scale = k * (1 << ES) + e;
    endfunction

    // Reference: exact product, re-encoded as an unbounded bit string, then RNE to N bits.
    function automatic void pmul(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] p, output logic nar, output logic zero);
        bit q[$];
        bit sa, sb, guard, sticky;
        int ska, skb, fla, flb, ep, msb, st, k, e, mag, rnd;
        longint ma, mb, mp;
        nar  = 1'b0;
        zero = 1'b0;
        if (a == NAR || b == NAR) begin p = NAR; nar = 1'b1; return; end
        if (a == '0 || b == '0) begin p = '0; zero = 1'b1; return; end
        pdecode(a, sa, ska, ma, fla);
        pdecode(b, sb, skb, mb, flb);
        mp  = ma * mb;
        ep  = ska - fla + skb - flb;
        msb = 63;
        while (msb > 0 && !mp[msb]) msb--;
        st = ep + msb;
        k  = st >>> ES;
        e  = st - k * (1 << ES);
        if (k >= 0) begin repeat (k + 1) q.push_back(1'b1); q.push_back(1'b0); end
        else begin repeat (-k) q.push_back(1'b0); q.push_back(1'b1); end
        for (int i = ES - 1; i >= 0; i--) q.push_back(e[i]);
        for (int i = msb - 1; i >= 0; i--) q.push_back(mp[i]);
        mag = 0;
        for (int i = 0; i < N - 1; i++) mag = mag * 2 + ((i < q.size()) ? int'(q[i]) : 0);
        guard  = (q.size() > N - 1) ? q[N-1] : 1'b0;
        sticky = 1'b0;
        for (int i = N; i < q.size(); i++) sticky |= q[i];
        rnd = mag + int'(guard && (sticky || mag % 2 == 1));
        if (rnd > int'(MAXP)) rnd = int'(MAXP);
        if (rnd == 0) rnd = 1;
        p = (sa ^ sb) ? N'(-rnd) : N'(rnd);
    endfunction

    function automatic logic [N-1:0] rand_posit();
        case ($urandom_range(0, 11))
            0:       return '0;
            1:       return NAR;
            2:       return MAXP;
            3:       return MINP;
            4:       return -MAXP;
            5:       return N'($urandom_range(1, 255));
            6:       return MAXP - N'($urandom_range(0, 255));
            default: return N'($urandom);
        endcase
    endfunction

    task automatic observe();
        exp_t e;
        logic [N-1:0] mp;
        logic mn, mz;
        accepted = 1'b0;
        chk("in_ready", io.in_ready, !(exp_q.size() == 3 && !io.out_ready));
        if (hold_pend) begin
            chk("hold_valid", io.out_valid, 1'b1);
            chk("hold_p", io.out_p, held_p);
            chk("hold_tag", io.out_tag, held_tag);
            chk("hold_nar", io.out_nar, held_nar);
            chk("hold_zero", io.out_zero, held_zero);
        end
        if (io.out_valid && exp_q.size() == 0) chk("stale_valid", io.out_valid, 1'b0);
        else if (io.out_valid && io.out_ready) begin
            e = exp_q.pop_front();
            chk("out_p", io.out_p, e.p);
            chk("out_tag", io.out_tag, e.tag);
            chk("out_nar", io.out_nar, e.nar);
            chk("out_zero", io.out_zero, e.zero);
            if (lat_chk) chk("latency", cyc - e.acc, 3);
            last_p    = io.out_p;
            last_tag  = io.out_tag;
            last_nar  = io.out_nar;
            last_zero = io.out_zero;
            delivered++;
        end
        if (io.in_valid && io.in_ready) begin
            pmul(io.in_a, io.in_b, mp, mn, mz);
            exp_q.push_back('{mp, mn, mz, io.in_tag, cyc});
            accepted = 1'b1;
        end
        hold_pend = io.out_valid && !io.out_ready;
        held_p    = io.out_p;
        held_tag  = io.out_tag;
        held_nar  = io.out_nar;
        held_zero = io.out_zero;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] ep, input logic en, input logic ez);
        int n;
        io.in_a      = a;
        io.in_b      = b;
        io.in_tag    = TAG_W'($urandom);
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!accepted && n < 10);
        io.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin tick(); n++; end
        chk({name, "_done"}, exp_q.size(), 0);
        chk({name, "_p"}, last_p, ep);
        chk({name, "_nar"}, last_nar, en);
        chk({name, "_zero"}, last_zero, ez);
    endtask

    task automatic stream(input int count, input int rdy_mode, input bit seq_tag);
        int sent, n, start_del;
        sent      = 0;
        n         = 0;
        start_del = delivered;
        io.in_valid = 1'b0;
        while ((sent < count || exp_q.size() > 0) && n < 4000) begin
            case (rdy_mode)
                0:       io.out_ready = 1'b1;
                1:       io.out_ready = RDY_PAT[n % 4] ^ ($urandom_range(0, 7) == 0);
                default: io.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!io.in_valid && sent < count && (rdy_mode == 0 || $urandom_range(0, 3) != 0)) begin
                io.in_a     = rand_posit();
                io.in_b     = rand_posit();
                io.in_tag   = seq_tag ? TAG_W'(sent) : TAG_W'($urandom);
                io.in_valid = 1'b1;
            end
            tick();
            n++;
            if (accepted) begin
                sent++;
                io.in_valid = 1'b0;
            end
        end
        io.in_valid = 1'b0;
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_count", delivered - start_del, count);
        if (rdy_mode == 0) chk("throughput_cycles", n, count + 3);
    endtask

    initial begin
        int n, sent;
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.in_tag    = '0;
        io.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", io.out_valid, 1'b0);
        chk("rst_out_p", io.out_p, 0);
        chk("rst_out_tag", io.out_tag, 0);
        chk("rst_out_nar", io.out_nar, 1'b0);
        chk("rst_out_zero", io.out_zero, 1'b0);
        chk("rst_in_ready", io.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        lat_chk = 1'b1;
        run_op("one_x_one",   16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
        run_op("two_x_two",   16'h4400, 16'h4400, 16'h4800, 1'b0, 1'b0);
        run_op("p15_x_p15",   16'h4200, 16'h4200, 16'h4480, 1'b0, 1'b0);
        run_op("neg_one_two", 16'hC000, 16'h4400, 16'hBC00, 1'b0, 1'b0);
        run_op("nar_x_zero",  16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0);
        run_op("zero_x_two",  16'h0000, 16'h4400, 16'h0000, 1'b0, 1'b1);
        run_op("sat_max",     16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        run_op("sat_min",     16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0);
        run_op("sat_negmax",  16'h8001, 16'h7FFF, 16'h8001, 1'b0, 1'b0);

        stream(40, 0, 1'b0);
        lat_chk = 1'b0;
        stream(8, 1, 1'b1);

        // Fill the pipe under backpressure, then reset with three operations in flight.
        io.out_ready = 1'b0;
        io.in_a      = 16'h4400;
        io.in_b      = 16'h4200;
        io.in_tag    = 4'd5;
        io.in_valid  = 1'b1;
        n    = 0;
        sent = 0;
        while (sent < 3 && n < 20) begin
            tick();
            n++;
            if (accepted) sent++;
        end
        io.in_valid = 1'b0;
        chk("inflight_before_rst", exp_q.size(), 3);
        chk("valid_before_rst", io.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", io.out_valid, 1'b0);
        chk("rst_async_p", io.out_p, 0);
        chk("rst_async_tag", io.out_tag, 0);
        chk("rst_async_in_ready", io.in_ready, 1'b1);
        exp_q.delete();
        hold_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        io.out_ready = 1'b1;
        repeat (6) tick();
        lat_chk = 1'b1;
        run_op("after_rst", 16'h4400, 16'h4400, 16'h4800, 1'b0, 1'b0);
        lat_chk = 1'b0;

        stream(200, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
